// File: rtl/alu_seq_if.sv
// alu_seq_if: command, ALU-side and response signals of the ALU sequencer.
interface alu_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_a;
    logic [2:0] cmd_b;
    logic       cmd_cin;
    logic [2:0] alu_in_0;
    logic [2:0] alu_in_1;
    logic       alu_M_0;
    logic       alu_M_1;
    logic       alu_c_in;
    logic [2:0] alu_out;
    logic       alu_c_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_data;
    logic       rsp_c_out;
    logic       rsp_zero;
    logic [7:0] op_count;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, alu_out, alu_c_out, rsp_ready,
        output cmd_ready, alu_in_0, alu_in_1, alu_M_0, alu_M_1, alu_c_in,
               rsp_valid, rsp_data, rsp_c_out, rsp_zero, op_count
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, alu_out, alu_c_out, rsp_ready,
        input  cmd_ready, alu_in_0, alu_in_1, alu_M_0, alu_M_1, alu_c_in,
               rsp_valid, rsp_data, rsp_c_out, rsp_zero, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one command, drives an external ALU, captures and holds the result.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

    state_t     state, state_nx;
    logic [1:0] op_q;
    logic [2:0] a_q, b_q, data_q;
    logic       cin_q, c_q, z_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = (state == IDLE)    ? (bus.cmd_valid ? DRIVE : IDLE) :
                   (state == DRIVE)   ? CAPTURE :
                   (state == CAPTURE) ? HOLD :
                                        (bus.rsp_ready ? IDLE : HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 2'd0;
            a_q    <= 3'd0;
            b_q    <= 3'd0;
            cin_q  <= 1'b0;
            data_q <= 3'd0;
            c_q    <= 1'b0;
            z_q    <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                op_q  <= bus.cmd_op;
                a_q   <= bus.cmd_a;
                b_q   <= bus.cmd_b;
                cin_q <= bus.cmd_cin;
            end
            // logical ops have no meaningful carry, so it is masked here
            if (state == CAPTURE) begin
                data_q <= bus.alu_out;
                c_q    <= ~op_q[1] & bus.alu_c_out;
                z_q    <= bus.alu_out == 3'd0;
            end
            if (state == HOLD && bus.rsp_ready) cnt_q <= cnt_q + 8'd1;
        end
    end

    always_comb begin
        bus.cmd_ready = state == IDLE;
        bus.rsp_valid = state == HOLD;
        bus.alu_in_0  = a_q;
        bus.alu_in_1  = b_q;
        bus.alu_M_0   = op_q[0];
        bus.alu_M_1   = op_q[1];
        bus.alu_c_in  = cin_q;
        bus.rsp_data  = data_q;
        bus.rsp_c_out = c_q;
        bus.rsp_zero  = z_q;
        bus.op_count  = cnt_q;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with a bench ALU and checks it against a transaction-level model.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if ifc();
    alu_sequencer dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    // {carry, result}; logical ops report a bogus carry of 1 that the sequencer must drop
    function automatic logic [3:0] alu_fn(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b, input logic c);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b} + {3'b0, c};
            2'd1:    return {1'b0, a} + {1'b0, ~b} + {3'b0, c};
            2'd2:    return {1'b1, a & b};
            default: return {1'b1, a ^ b};
        endcase
    endfunction

    // bench ALU: shows inverted garbage for the cycle after its inputs change
    logic [8:0] prev;
    logic [3:0] alu_r;
    always @(posedge clk) prev <= {ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in};
    always_comb begin
        alu_r = alu_fn({ifc.alu_M_1, ifc.alu_M_0}, ifc.alu_in_0, ifc.alu_in_1, ifc.alu_c_in);
        ifc.alu_c_out = alu_r[3];
        ifc.alu_out = (prev == {ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in}) ? alu_r[2:0] : ~alu_r[2:0];
    end

    // reference model: idle flag plus cycles elapsed since the accepted command
    logic       m_idle, m_c, m_z, m_cin;
    int         m_age;
    logic [1:0] m_op;
    logic [2:0] m_a, m_b, m_d;
    logic [7:0] m_cnt;
    logic [3:0] m_r;
    always_comb m_r = alu_fn(m_op, m_a, m_b, m_cin);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle <= 1'b1; m_age <= 0; m_op <= 2'd0; m_a <= 3'd0; m_b <= 3'd0; m_cin <= 1'b0;
            m_d <= 3'd0; m_c <= 1'b0; m_z <= 1'b0; m_cnt <= 8'd0;
        end else if (m_idle) begin
            if (ifc.cmd_valid) begin
                m_idle <= 1'b0; m_age <= 0;
                m_op <= ifc.cmd_op; m_a <= ifc.cmd_a; m_b <= ifc.cmd_b; m_cin <= ifc.cmd_cin;
            end
        end else begin
            if (m_age == 1) begin
                m_d <= m_r[2:0];
                m_c <= ~m_op[1] & m_r[3];
                m_z <= m_r[2:0] == 3'd0;
            end
            if (m_age >= 2 && ifc.rsp_ready) begin
                m_cnt  <= m_cnt + 8'd1;
                m_idle <= 1'b1;
            end
            m_age <= m_age + 1;
        end
    end

    logic [23:0] act_v, exp_v;
    int          cyc = 0;
    always @(negedge clk) begin
        cyc++;
        exp_v = {m_idle, !m_idle && m_age >= 2, m_d, m_c, m_z, m_cnt, m_a, m_b, m_op, m_cin};
        act_v = {ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_data, ifc.rsp_c_out, ifc.rsp_zero, ifc.op_count,
                 ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model cycle %0d: got %h expected %h", cyc, act_v, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // offers a command, returns at negedge+1 in the cycle after the accepting edge
    task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b, input logic c);
        int n = 0;
        @(negedge clk); #1;
        ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_a = a; ifc.cmd_b = b; ifc.cmd_cin = c;
        while (!ifc.cmd_ready && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (n == 40) chk("send_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
        ifc.cmd_valid = 1'b0;
    endtask

    initial begin
        int rc;
        ifc.cmd_valid = 1'b0; ifc.cmd_op = 2'd0; ifc.cmd_a = 3'd0; ifc.cmd_b = 3'd0;
        ifc.cmd_cin = 1'b0; ifc.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", ifc.cmd_ready, 1);
        chk("reset_valid", ifc.rsp_valid, 0);
        chk("reset_count", ifc.op_count, 0);
        chk("reset_alu", {ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in}, 0);

        #1 ifc.rsp_ready = 1'b1;
        send(2'd0, 3'd3, 3'd5, 1'b0);
        chk("add_mode", {ifc.alu_M_1, ifc.alu_M_0}, 0);
        chk("add_drive_valid", ifc.rsp_valid, 0);
        @(negedge clk);
        chk("add_capture_valid", ifc.rsp_valid, 0);
        @(negedge clk);
        chk("add_valid", ifc.rsp_valid, 1);
        chk("add_data", ifc.rsp_data, 0);
        chk("add_cout", ifc.rsp_c_out, 1);
        chk("add_zero", ifc.rsp_zero, 1);
        @(negedge clk);
        chk("add_count", ifc.op_count, 1);
        chk("add_done_valid", ifc.rsp_valid, 0);

        send(2'd2, 3'd6, 3'd3, 1'b0);
        chk("and_mode", {ifc.alu_M_1, ifc.alu_M_0}, 2'b10);
        repeat (2) @(negedge clk);
        chk("and_data", ifc.rsp_data, 2);
        chk("and_cout", ifc.rsp_c_out, 0);
        chk("and_zero", ifc.rsp_zero, 0);

        @(negedge clk); #1 ifc.rsp_ready = 1'b0;
        send(2'd3, 3'd5, 3'd6, 1'b1);
        ifc.cmd_valid = 1'b1; ifc.cmd_op = 2'd1; ifc.cmd_a = 3'd7; ifc.cmd_b = 3'd2; ifc.cmd_cin = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", ifc.rsp_valid, 1);
            chk("hold_rsp", {ifc.rsp_data, ifc.rsp_c_out, ifc.rsp_zero}, {3'd3, 1'b0, 1'b0});
            chk("hold_ready", ifc.cmd_ready, 0);
            chk("hold_alu", {ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in}, {3'd5, 3'd6, 3'b111});
            @(negedge clk);
        end
        #1 ifc.rsp_ready = 1'b1;
        @(negedge clk);
        chk("second_idle", ifc.cmd_ready, 1);
        @(negedge clk);
        chk("second_alu", {ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in}, {3'd7, 3'd2, 3'b011});
        #1 ifc.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sub_rsp", {ifc.rsp_data, ifc.rsp_c_out, ifc.rsp_zero}, {3'd5, 1'b1, 1'b0});

        @(negedge clk);
        send(2'd0, 3'd1, 3'd1, 1'b0);
        @(negedge clk); #1 rst = 1'b1;
        #1;
        chk("abort_ready", ifc.cmd_ready, 1);
        chk("abort_rsp", {ifc.rsp_valid, ifc.rsp_data, ifc.rsp_c_out, ifc.rsp_zero}, 0);
        chk("abort_count", ifc.op_count, 0);
        chk("abort_alu", {ifc.alu_in_0, ifc.alu_in_1, ifc.alu_M_1, ifc.alu_M_0, ifc.alu_c_in}, 0);
        @(negedge clk); #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_valid", ifc.rsp_valid, 0);
            chk("abort_count_hold", ifc.op_count, 0);
        end

        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            ifc.cmd_valid = 1'($urandom_range(0, 1));
            ifc.cmd_op = 2'($urandom); ifc.cmd_a = 3'($urandom); ifc.cmd_b = 3'($urandom);
            ifc.cmd_cin = 1'($urandom);
            ifc.rsp_ready = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 49) == 0;
        end

        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk); #1 rst = 1'b0;
        ifc.rsp_ready = 1'b1; ifc.cmd_valid = 1'b1;
        rc = 0;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            if (ifc.cmd_ready) rc++;
            if (i == 1020) chk("wrap_pre", ifc.op_count, 8'hFF);
            #1;
            ifc.cmd_op = 2'($urandom); ifc.cmd_a = 3'($urandom); ifc.cmd_b = 3'($urandom);
            ifc.cmd_cin = 1'($urandom);
        end
        chk("wrap_zero", ifc.op_count, 0);
        chk("period_accepts", rc, 256);
        ifc.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
